// File: rtl/itcm_ctrl_if.sv
// itcm_ctrl_if: IFU/LSU command-response channels plus the ITCM RAM macro port.
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 10
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif
`ifndef ITCM_RAM_MW
`define ITCM_RAM_MW 4
`endif

interface itcm_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned AW     = `ITCM_RAM_AW,
  parameter int unsigned DW     = `ITCM_RAM_DW,
  parameter int unsigned MW     = `ITCM_RAM_MW
) ();

  // Instruction-fetch port (read only)
  logic              ifu_cmd_valid;
  logic              ifu_cmd_ready;
  logic [ADDR_W-1:0] ifu_cmd_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DW-1:0]     ifu_rsp_rdata;
  logic              ifu_rsp_err;

  // Load/store port
  logic              lsu_cmd_valid;
  logic              lsu_cmd_ready;
  logic              lsu_cmd_read;
  logic [ADDR_W-1:0] lsu_cmd_addr;
  logic [DW-1:0]     lsu_cmd_wdata;
  logic [MW-1:0]     lsu_cmd_wmask;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DW-1:0]     lsu_rsp_rdata;
  logic              lsu_rsp_err;

  // Single-port RAM macro
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic [MW-1:0]     ram_wem;
  logic [DW-1:0]     ram_dout;

  modport slave (
    input  ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
    input  lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask, lsu_rsp_ready,
    input  ram_dout,
    output ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    output lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    output ram_we, ram_addr, ram_din, ram_wem
  );

  modport master (
    output ifu_cmd_valid, ifu_cmd_addr, ifu_rsp_ready,
    output lsu_cmd_valid, lsu_cmd_read, lsu_cmd_addr, lsu_cmd_wdata, lsu_cmd_wmask, lsu_rsp_ready,
    output ram_dout,
    input  ifu_cmd_ready, ifu_rsp_valid, ifu_rsp_rdata, ifu_rsp_err,
    input  lsu_cmd_ready, lsu_rsp_valid, lsu_rsp_rdata, lsu_rsp_err,
    input  ram_we, ram_addr, ram_din, ram_wem
  );

endinterface

// File: rtl/itcm_ctrl.sv
// itcm_ctrl: arbitrates IFU fetches and LSU loads/stores onto the single-port ITCM RAM,
// one transaction in flight, one response per accepted command.
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 10
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif
`ifndef ITCM_RAM_MW
`define ITCM_RAM_MW 4
`endif

module itcm_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned AW         = `ITCM_RAM_AW,
  parameter int unsigned DW         = `ITCM_RAM_DW,
  parameter int unsigned MW         = `ITCM_RAM_MW,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic        clk,
  input logic        rst_n,
  itcm_ctrl_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RSP  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = LSU owns the response, 0 = IFU
  logic            err_q, err_d;
  logic            zero_q, zero_d;     // response data forced to 0 (write or error)
  logic [DW-1:0]   hold_q, hold_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic              owner_rsp_ready_c;
  logic              can_accept_c;
  logic              grant_ifu_c;
  logic              grant_lsu_c;
  logic              accept_c;
  logic              oor_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DW-1:0]     rsp_data_c;
  logic              unused_addr_lsb_c;

  // Arbitration: LSU priority, IFU forced in once the starve counter saturates
  always_comb begin
    owner_rsp_ready_c = owner_q ? bus.lsu_rsp_ready : bus.ifu_rsp_ready;
    can_accept_c      = (state_q == S_IDLE) || owner_rsp_ready_c;
    grant_ifu_c       = can_accept_c && bus.ifu_cmd_valid &&
                        (!bus.lsu_cmd_valid || (starve_q == STARVE_MAX));
    grant_lsu_c       = can_accept_c && bus.lsu_cmd_valid && !grant_ifu_c;
    accept_c          = grant_ifu_c || grant_lsu_c;
    sel_addr_c        = grant_lsu_c ? bus.lsu_cmd_addr : bus.ifu_cmd_addr;
    oor_c             = |sel_addr_c[ADDR_W-1:AW+2];
    rsp_data_c        = (state_q == S_RSP) ? (zero_q ? '0 : bus.ram_dout) : hold_q;
  end

  // Byte offset within a word carries no meaning for word-wide accesses
  assign unused_addr_lsb_c = ^{bus.ifu_cmd_addr[1:0], bus.lsu_cmd_addr[1:0]};

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: a retiring response may be replaced by a new one in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_RSP;
      end
      S_RSP, S_HOLD: begin
        if (owner_rsp_ready_c) state_d = accept_c ? S_RSP : S_IDLE;
        else                   state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshakes and RAM drive in the accept cycle, response to the owner only
  always_comb begin
    bus.ifu_cmd_ready = 1'b0;
    bus.lsu_cmd_ready = 1'b0;
    bus.ram_we        = 1'b0;
    bus.ram_addr      = '0;
    bus.ram_din       = '0;
    bus.ram_wem       = {MW{1'b0}};
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_rdata = '0;
    bus.ifu_rsp_err   = 1'b0;
    bus.lsu_rsp_valid = 1'b0;
    bus.lsu_rsp_rdata = '0;
    bus.lsu_rsp_err   = 1'b0;
    if (rst_n && accept_c) begin
      bus.ifu_cmd_ready = grant_ifu_c;
      bus.lsu_cmd_ready = grant_lsu_c;
      bus.ram_addr      = sel_addr_c[AW+1:2];
      bus.ram_we        = grant_lsu_c && !bus.lsu_cmd_read && !oor_c;
      if (grant_lsu_c) begin
        bus.ram_din = bus.lsu_cmd_wdata;
        bus.ram_wem = bus.lsu_cmd_wmask;
      end
    end
    if (state_q != S_IDLE) begin
      if (owner_q) begin
        bus.lsu_rsp_valid = 1'b1;
        bus.lsu_rsp_rdata = rsp_data_c;
        bus.lsu_rsp_err   = err_q;
      end else begin
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_rdata = rsp_data_c;
        bus.ifu_rsp_err   = err_q;
      end
    end
  end

  // Transaction attributes, hold capture and starvation counter
  always_comb begin
    owner_d  = owner_q;
    err_d    = err_q;
    zero_d   = zero_q;
    hold_d   = hold_q;
    starve_d = starve_q;
    if (accept_c) begin
      owner_d = grant_lsu_c;
      err_d   = oor_c;
      zero_d  = oor_c || (grant_lsu_c && !bus.lsu_cmd_read);
    end
    // RAM output is only valid for one cycle; park it when the owner stalls
    if ((state_q == S_RSP) && !owner_rsp_ready_c) hold_d = rsp_data_c;
    if (grant_ifu_c || !bus.ifu_cmd_valid) begin
      starve_d = '0;
    end else if (grant_lsu_c && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      hold_q   <= '0;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      hold_q   <= hold_d;
      starve_q <= starve_d;
    end
  end

endmodule
